// File: rtl/timer_counter.sv
// Count stage of the 16-bit timer: synchronizes the divided clock clk_in into pclk,
// turns its rising edges into a one-cycle tick and drives an up/down counter with wrap flags.
module timer_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             clk_in,
    input  logic             tcr_en,
    input  logic             tcr_dir,
    input  logic             tcr_load,
    input  logic [CNT_W-1:0] tdr,
    input  logic             clr_ovf,
    input  logic             clr_udf,
    output logic [CNT_W-1:0] tcnt,
    output logic             tick,
    output logic             tsr_ovf,
    output logic             tsr_udf,
    output logic             ovf_irq,
    output logic             udf_irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;
    logic                   s_last;
    logic                   cnt_step;
    logic                   ovf_evt;
    logic                   udf_evt;

    assign s_last = sync_q[SYNC_STAGES-1];

    // clk_in is only ever sampled as data; the edge detector runs entirely on pclk.
    // NOTE: every sequential block uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            s_prev <= s_last;
            tick   <= s_last & ~s_prev;
        end
    end

    // A load always takes precedence, so a coincident tick is swallowed without side effects.
    assign cnt_step = tcr_en & tick & ~tcr_load;
    assign ovf_evt  = cnt_step & ~tcr_dir & (tcnt == '1);
    assign udf_evt  = cnt_step &  tcr_dir & (tcnt == '0);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tcnt <= '0;
        end else if (tcr_load) begin
            tcnt <= tdr;
        end else if (cnt_step) begin
            tcnt <= tcr_dir ? (tcnt - CNT_ONE) : (tcnt + CNT_ONE);
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tsr_ovf <= 1'b0;
            tsr_udf <= 1'b0;
            ovf_irq <= 1'b0;
            udf_irq <= 1'b0;
        end else begin
            tsr_ovf <= ovf_evt | (tsr_ovf & ~clr_ovf);
            tsr_udf <= udf_evt | (tsr_udf & ~clr_udf);
            ovf_irq <= ovf_evt;
            udf_irq <= udf_evt;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a bench-side scoreboard holds the expected
// counter/flag state after each counted tick; scenario tasks add their own inline checks.
module tb_timer_counter;

    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 1;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             udf;
        logic             ovf_irq;
        logic             udf_irq;
    } exp_t;

    logic             pclk = 1'b0;
    logic             preset_n;
    logic             clk_in;
    logic             tcr_en;
    logic             tcr_dir;
    logic             tcr_load;
    logic [CNT_W-1:0] tdr;
    logic             clr_ovf;
    logic             clr_udf;
    logic [CNT_W-1:0] tcnt;
    logic             tick;
    logic             tsr_ovf;
    logic             tsr_udf;
    logic             ovf_irq;
    logic             udf_irq;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic sb_arm   = 1'b0;
    logic clk_run  = 1'b0;
    logic gen_ph   = 1'b0;

    timer_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clk_in   (clk_in),
        .tcr_en   (tcr_en),
        .tcr_dir  (tcr_dir),
        .tcr_load (tcr_load),
        .tdr      (tdr),
        .clr_ovf  (clr_ovf),
        .clr_udf  (clr_udf),
        .tcnt     (tcnt),
        .tick     (tick),
        .tsr_ovf  (tsr_ovf),
        .tsr_udf  (tsr_udf),
        .ovf_irq  (ovf_irq),
        .udf_irq  (udf_irq)
    );

    initial forever #5 pclk = ~pclk;

    // Divided-clock source: pclk/4, toggled on falling pclk edges.
    initial forever begin
        @(negedge pclk);
        if (clk_run) begin
            if (gen_ph) clk_in = ~clk_in;
            gen_ph = ~gen_ph;
        end
    end

    // Scoreboard consumer: every edge that used a high tick pops one expected state.
    initial begin
        logic tick_d;
        logic post_upd;
        exp_t e;
        exp_t got;
        tick_d   = 1'b0;
        post_upd = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (sb_arm && post_upd) begin
                checks++;
                if (tick !== 1'b0 || ovf_irq !== 1'b0 || udf_irq !== 1'b0) begin
                    failures++;
                    $display("FAIL single_pulse: tick=%b ovf_irq=%b udf_irq=%b, required all 0",
                             tick, ovf_irq, udf_irq);
                end
            end
            post_upd = 1'b0;
            if (sb_arm && tick_d) begin
                checks++;
                got = {tcnt, tsr_ovf, tsr_udf, ovf_irq, udf_irq};
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: update with tcnt=%h but no expectation queued", tcnt);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e)
                        begin
                            failures++;
                            $display("FAIL sb_update: got cnt=%h ovf=%b udf=%b oirq=%b uirq=%b, required cnt=%h ovf=%b udf=%b oirq=%b uirq=%b",
                                     got.cnt, got.ovf, got.udf, got.ovf_irq, got.udf_irq,
                                     e.cnt, e.ovf, e.udf, e.ovf_irq, e.udf_irq);
                        end
                end
                post_upd = 1'b1;
            end
            tick_d = tick;
        end
    end

    task automatic push(input logic [CNT_W-1:0] c, input logic o, input logic u,
                        input logic oi, input logic ui);
        exp_t e;
        e = '{cnt: c, ovf: o, udf: u, ovf_irq: oi, udf_irq: ui};
        sb_q.push_back(e);
    endtask

    // Stop the divided clock with counting disabled so no stray tick reaches the counter.
    task automatic idle();
        @(posedge pclk); #1;
        tcr_en   = 1'b0;
        clk_run  = 1'b0;
        clk_in   = 1'b0;
        tcr_load = 1'b0;
        clr_ovf  = 1'b0;
        clr_udf  = 1'b0;
        repeat (8) @(posedge pclk);
        #1;
    endtask

    task automatic load(input logic [CNT_W-1:0] v);
        tdr      = v;
        tcr_load = 1'b1;
        @(posedge pclk); #1;
        tcr_load = 1'b0;
    endtask

    task automatic start_clk();
        clk_in  = 1'b0;
        gen_ph  = 1'b1;
        clk_run = 1'b1;
    endtask

    task automatic count_to_tick(output int n);
        n = 0;
        do begin
            @(posedge pclk); #1;
            n++;
        end while (tick !== 1'b1 && n < 20);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge pclk); #2;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expectations left, required 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge pclk);
        sb_arm = 1'b0;
    endtask

    task automatic test_reset();
        int n_ticks;
        preset_n = 1'b0;
        clk_in = 1'b1; tcr_en = 1'b0; tcr_dir = 1'b0; tcr_load = 1'b0;
        tdr = '0; clr_ovf = 1'b0; clr_udf = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({tcnt, tick, tsr_ovf, tsr_udf, ovf_irq, udf_irq} !== '0) begin
            failures++;
            $display("FAIL reset_state: tcnt=%h tick=%b ovf=%b udf=%b oirq=%b uirq=%b, required all 0",
                     tcnt, tick, tsr_ovf, tsr_udf, ovf_irq, udf_irq);
        end
        #1 preset_n = 1'b1;
        n_ticks = 0;
        repeat (15) begin
            @(posedge pclk); #1;
            if (tick === 1'b1) n_ticks++;
        end
        checks++;
        if (n_ticks != 1 || tcnt !== '0) begin
            failures++;
            $display("FAIL high_from_reset: ticks=%0d tcnt=%h, required ticks=1 tcnt=0000", n_ticks, tcnt);
        end
    endtask

    task automatic test_count_up();
        int n;
        idle();
        tcr_dir = 1'b0;
        tcr_en  = 1'b1;
        push(16'h0001, 0, 0, 0, 0);
        push(16'h0002, 0, 0, 0, 0);
        push(16'h0003, 0, 0, 0, 0);
        sb_arm = 1'b1;
        start_clk();
        @(posedge clk_in);
        count_to_tick(n);
        checks++;
        if (n != LAT) begin
            failures++;
            $display("FAIL first_tick_latency: %0d edges, required %0d", n, LAT);
        end
        count_to_tick(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL tick_interval: %0d edges, required 4", n);
        end
        drain("count_up");
    endtask

    task automatic test_overflow();
        idle();
        tcr_dir = 1'b0;
        load(16'hFFFE);
        tcr_en = 1'b1;
        push(16'hFFFF, 0, 0, 0, 0);
        push(16'h0000, 1, 0, 1, 0);
        push(16'h0001, 1, 0, 0, 0);
        sb_arm = 1'b1;
        start_clk();
        drain("overflow");
    endtask

    task automatic test_underflow();
        idle();
        clr_ovf = 1'b1;
        clr_udf = 1'b1;
        @(posedge pclk); #1;
        clr_ovf = 1'b0;
        clr_udf = 1'b0;
        tcr_dir = 1'b1;
        load(16'h0001);
        tcr_en = 1'b1;
        push(16'h0000, 0, 0, 0, 0);
        push(16'hFFFF, 0, 1, 0, 1);
        push(16'hFFFE, 0, 1, 0, 0);
        sb_arm = 1'b1;
        start_clk();
        drain("underflow");
    endtask

    task automatic test_clr_collision();
        int n;
        idle();
        clr_udf = 1'b1;
        @(posedge pclk); #1;
        clr_udf = 1'b0;
        tcr_dir = 1'b0;
        load(16'hFFFF);
        tcr_en = 1'b1;
        start_clk();
        count_to_tick(n);
        // The next edge wraps the counter; clear is held across it and the one after.
        clr_ovf = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if ({tcnt, tsr_ovf, tsr_udf, ovf_irq} !== {16'h0000, 3'b101}) begin
            failures++;
            $display("FAIL set_beats_clear: tcnt=%h ovf=%b udf=%b oirq=%b, required tcnt=0000 ovf=1 udf=0 oirq=1",
                     tcnt, tsr_ovf, tsr_udf, ovf_irq);
        end
        @(posedge pclk); #1;
        clr_ovf = 1'b0;
        checks++;
        if (tsr_ovf !== 1'b0 || ovf_irq !== 1'b0) begin
            failures++;
            $display("FAIL clear_after: ovf=%b oirq=%b, required ovf=0 oirq=0", tsr_ovf, ovf_irq);
        end
    endtask

    task automatic test_load_tick();
        int n;
        idle();
        tcr_dir = 1'b0;
        tcr_en  = 1'b1;
        start_clk();
        count_to_tick(n);
        tdr      = 16'h1234;
        tcr_load = 1'b1;
        @(posedge pclk); #1;
        tcr_load = 1'b0;
        tcr_en   = 1'b0;
        checks++;
        if (tcnt !== 16'h1234) begin
            failures++;
            $display("FAIL load_with_tick: tcnt=%h, required 1234", tcnt);
        end
        for (int i = 0; i < 5; i++) begin
            count_to_tick(n);
            @(posedge pclk); #1;
            checks++;
            if (n >= 20 || tcnt !== 16'h1234 || ovf_irq !== 1'b0) begin
                failures++;
                $display("FAIL hold_disabled_%0d: tcnt=%h wait=%0d oirq=%b, required tcnt=1234 within 20 edges oirq=0",
                         i, tcnt, n, ovf_irq);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        int n_ticks;
        idle();
        tcr_dir = 1'b0;
        load(16'hFFFF);
        tcr_en = 1'b1;
        start_clk();
        count_to_tick(n);
        @(posedge pclk); #1;
        idle();
        load(16'h00A4);
        tcr_en = 1'b1;
        start_clk();
        count_to_tick(n);
        @(posedge pclk); #1;
        checks++;
        if (tcnt !== 16'h00A5 || tsr_ovf !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: tcnt=%h ovf=%b, required tcnt=00A5 ovf=1", tcnt, tsr_ovf);
        end
        #2;
        preset_n = 1'b0;
        clk_run  = 1'b0;
        clk_in   = 1'b0;
        #1;
        checks++;
        if ({tcnt, tick, tsr_ovf, tsr_udf, ovf_irq, udf_irq} !== '0) begin
            failures++;
            $display("FAIL async_reset: tcnt=%h tick=%b ovf=%b udf=%b oirq=%b uirq=%b, required all 0 before any edge",
                     tcnt, tick, tsr_ovf, tsr_udf, ovf_irq, udf_irq);
        end
        repeat (3) @(posedge pclk);
        #2 preset_n = 1'b1;
        n_ticks = 0;
        repeat (8) begin
            @(posedge pclk); #1;
            if (tick === 1'b1) n_ticks++;
        end
        checks++;
        if (n_ticks != 0 || tcnt !== '0) begin
            failures++;
            $display("FAIL no_stale_tick: ticks=%0d tcnt=%h, required ticks=0 tcnt=0000", n_ticks, tcnt);
        end
        clk_in = 1'b1;
        count_to_tick(n);
        @(posedge pclk); #1;
        checks++;
        if (n != LAT || tcnt !== 16'h0001) begin
            failures++;
            $display("FAIL fresh_rise: latency=%0d tcnt=%h, required latency=%0d tcnt=0001", n, tcnt, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_overflow();
        test_underflow();
        test_clr_collision();
        test_load_tick();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
